// File: rtl/rv32_csr_decode_if.sv
// Decode/execute boundary for the Zicsr decode stage: instruction in,
// interlock handshake, and registered CSR control fields out.
interface rv32_csr_decode_if;
    logic        stall_in;
    logic        flush_in;
    logic        valid_in;
    logic [31:0] instr_in;
    logic        csr_write_retired_in;
    logic        stall_out;
    logic        valid_out;
    logic        csr_read_out;
    logic        csr_write_out;
    logic [1:0]  csr_write_op_out;
    logic        csr_src_out;
    logic [11:0] csr_out;
    logic [31:0] imm_value_out;
    logic [4:0]  rd_out;
    logic        illegal_out;

    modport master (
        output stall_in, flush_in, valid_in, instr_in, csr_write_retired_in,
        input  stall_out, valid_out, csr_read_out, csr_write_out, csr_write_op_out,
               csr_src_out, csr_out, imm_value_out, rd_out, illegal_out
    );

    modport slave (
        input  stall_in, flush_in, valid_in, instr_in, csr_write_retired_in,
        output stall_out, valid_out, csr_read_out, csr_write_out, csr_write_op_out,
               csr_src_out, csr_out, imm_value_out, rd_out, illegal_out
    );
endinterface

// File: rtl/rv32_csr_decode.sv
// Zicsr decode stage: decodes CSR ops, checks address legality, registers
// the execute-side control fields and holds a one-deep CSR write interlock.
module rv32_csr_decode (
    input logic              clk,
    input logic              reset,
    rv32_csr_decode_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic        read;
        logic        write;
        logic [1:0]  op;
        logic        src;
        logic [11:0] csr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        illegal;
    } ex_t;

    function automatic logic csr_implemented(input logic [11:0] a);
        csr_implemented = (a == 12'h300) || (a == 12'h301) || (a == 12'h304) || (a == 12'h305)
                       || (a >= 12'h323 && a <= 12'h344)
                       || (a >= 12'h3A0 && a <= 12'h3A3)
                       || (a >= 12'h3B0 && a <= 12'h3BF)
                       || (a == 12'hB00) || (a >= 12'hB02 && a <= 12'hB1F)
                       || (a == 12'hB80) || (a >= 12'hB82 && a <= 12'hB9F)
                       || (a >= 12'hC00 && a <= 12'hC02)
                       || (a >= 12'hC80 && a <= 12'hC82)
                       || (a >= 12'hF11 && a <= 12'hF14);
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1;
    logic [11:0] csr;
    logic        is_csr, is_rw, rd_en, wr_en, illegal, stall;
    logic        pending;
    ex_t         ex_q, ex_d;

    assign opcode  = bus.instr_in[6:0];
    assign funct3  = bus.instr_in[14:12];
    assign rd      = bus.instr_in[11:7];
    assign rs1     = bus.instr_in[19:15];
    assign csr     = bus.instr_in[31:20];
    assign is_csr  = (opcode == 7'b1110011) && (funct3[1:0] != 2'b00);
    assign is_rw   = (funct3[1:0] == 2'b01);
    assign rd_en   = !(is_rw && rd == 5'd0);
    assign wr_en   = is_rw || (rs1 != 5'd0);
    // Writes to csr[11:10]==11 are illegal even when the address exists.
    assign illegal = is_csr && (!csr_implemented(csr) || (wr_en && csr[11:10] == 2'b11));

    // Deliberately independent of stall_in so execute can stall on us without a loop.
    assign stall = bus.valid_in && is_csr && pending && !bus.flush_in;

    always_comb begin
        ex_d = '0;
        if (bus.valid_in && !stall) begin
            ex_d.valid   = 1'b1;
            ex_d.csr     = csr;
            ex_d.imm     = {27'd0, rs1};
            ex_d.rd      = rd;
            if (is_csr) begin
                ex_d.op      = funct3[1:0] - 2'd1;
                ex_d.src     = !funct3[2];
                ex_d.illegal = illegal;
                ex_d.read    = rd_en && !illegal;
                ex_d.write   = wr_en && !illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush_in)
            ex_q <= '0;
        else if (!bus.stall_in)
            ex_q <= ex_d;
    end

    // A new set beats a simultaneous retire: the retire belongs to the older write.
    always_ff @(posedge clk) begin
        if (reset || bus.flush_in)
            pending <= 1'b0;
        else if (!bus.stall_in && ex_d.write)
            pending <= 1'b1;
        else if (bus.csr_write_retired_in)
            pending <= 1'b0;
    end

    assign bus.stall_out        = stall;
    assign bus.valid_out        = ex_q.valid;
    assign bus.csr_read_out     = ex_q.read;
    assign bus.csr_write_out    = ex_q.write;
    assign bus.csr_write_op_out = ex_q.op;
    assign bus.csr_src_out      = ex_q.src;
    assign bus.csr_out          = ex_q.csr;
    assign bus.imm_value_out    = ex_q.imm;
    assign bus.rd_out           = ex_q.rd;
    assign bus.illegal_out      = ex_q.illegal;
endmodule

// File: tb/tb_rv32_csr_decode.sv
// Directed bench for rv32_csr_decode: decode fields, legality, interlock,
// flush, stall hold and reset, with hand-computed expectations.
module tb_rv32_csr_decode;
    logic clk = 1'b0;
    logic reset;
    int   n_eval = 0;
    int   n_fail = 0;

    rv32_csr_decode_if bus ();
    rv32_csr_decode dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] csr_i(input logic [11:0] c, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {c, rs1, f3, rd, 7'b1110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_eval++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic r, input logic w,
                              input logic [1:0] op, input logic src, input logic [11:0] c,
                              input logic [31:0] imm, input logic [4:0] rd, input logic ill);
        chk({tag, ".valid"},   bus.valid_out,        v);
        chk({tag, ".read"},    bus.csr_read_out,     r);
        chk({tag, ".write"},   bus.csr_write_out,    w);
        chk({tag, ".op"},      bus.csr_write_op_out, op);
        chk({tag, ".src"},     bus.csr_src_out,      src);
        chk({tag, ".csr"},     bus.csr_out,          c);
        chk({tag, ".imm"},     bus.imm_value_out,    imm);
        chk({tag, ".rd"},      bus.rd_out,           rd);
        chk({tag, ".illegal"}, bus.illegal_out,      ill);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] i1, i2, i7, i8;
        i1 = csr_i(12'h340, 5'd6, 3'b001, 5'd5);  // csrrw x5, mscratch, x6
        i2 = csr_i(12'h340, 5'd0, 3'b010, 5'd7);  // csrrs x7, mscratch, x0
        i7 = csr_i(12'h340, 5'd0, 3'b010, 5'd3);  // csrrs x3, mscratch, x0
        i8 = csr_i(12'h305, 5'd8, 3'b001, 5'd4);  // csrrw x4, mtvec, x8

        reset = 1'b1;
        bus.stall_in = 1'b0; bus.flush_in = 1'b0; bus.valid_in = 1'b0;
        bus.instr_in = '0;   bus.csr_write_retired_in = 1'b0;
        tick(); tick();
        expect_out("reset", 0, 0, 0, 2'b00, 0, 12'h000, 32'd0, 5'd0, 0);
        reset = 1'b0;

        // CSRRW sets pending; the following CSRRS is interlocked
        bus.valid_in = 1'b1; bus.instr_in = i1; #1;
        chk("i1.stall_out", bus.stall_out, 1'b0);
        tick();
        expect_out("i1", 1, 1, 1, 2'b00, 1, 12'h340, 32'd6, 5'd5, 0);
        bus.instr_in = i2; #1;
        chk("i2.stall_pending", bus.stall_out, 1'b1);
        tick();
        chk("i2.bubble_valid", bus.valid_out, 1'b0);
        chk("i2.bubble_write", bus.csr_write_out, 1'b0);
        bus.csr_write_retired_in = 1'b1; #1;
        chk("i2.stall_retire_cycle", bus.stall_out, 1'b1);
        tick();
        bus.csr_write_retired_in = 1'b0;
        chk("i2.bubble2_valid", bus.valid_out, 1'b0);
        #1;
        chk("i2.stall_released", bus.stall_out, 1'b0);
        tick();
        expect_out("i2", 1, 1, 0, 2'b01, 1, 12'h340, 32'd0, 5'd7, 0);

        // csrrs x1, cycle, x0: read-only CSR, no write -> legal
        bus.instr_in = csr_i(12'hC00, 5'd0, 3'b010, 5'd1); #1;
        chk("i3.stall_out", bus.stall_out, 1'b0);
        tick();
        expect_out("i3", 1, 1, 0, 2'b01, 1, 12'hC00, 32'd0, 5'd1, 0);

        // csrrwi x0, cycle, 3: write to read-only
        bus.instr_in = csr_i(12'hC00, 5'd3, 3'b101, 5'd0); #1;
        chk("i4.stall_out", bus.stall_out, 1'b0);
        tick();
        expect_out("i4", 1, 0, 0, 2'b00, 0, 12'hC00, 32'd3, 5'd0, 1);

        // unimplemented address 7C0
        bus.instr_in = csr_i(12'h7C0, 5'd0, 3'b010, 5'd2); #1;
        chk("i5.stall_out", bus.stall_out, 1'b0);
        tick();
        expect_out("i5", 1, 0, 0, 2'b01, 1, 12'h7C0, 32'd0, 5'd2, 1);

        // set pending again, then non-CSR instructions must not stall
        bus.instr_in = csr_i(12'h340, 5'd2, 3'b001, 5'd1);
        tick();
        expect_out("i6", 1, 1, 1, 2'b00, 1, 12'h340, 32'd2, 5'd1, 0);
        bus.instr_in = 32'h0050_0093; #1;  // addi x1, x0, 5
        chk("addi.stall_out", bus.stall_out, 1'b0);
        tick();
        chk("addi.valid", bus.valid_out, 1'b1);
        chk("addi.read", bus.csr_read_out, 1'b0);
        chk("addi.write", bus.csr_write_out, 1'b0);
        chk("addi.illegal", bus.illegal_out, 1'b0);
        bus.instr_in = 32'h0000_0073; #1;  // ecall: SYSTEM opcode, funct3=000
        chk("ecall.stall_out", bus.stall_out, 1'b0);
        tick();
        chk("ecall.valid", bus.valid_out, 1'b1);
        chk("ecall.read", bus.csr_read_out, 1'b0);
        chk("ecall.illegal", bus.illegal_out, 1'b0);

        // flush while pending
        bus.instr_in = i7; #1;
        chk("i7.stall_pending", bus.stall_out, 1'b1);
        bus.flush_in = 1'b1; #1;
        chk("flush.stall_out", bus.stall_out, 1'b0);
        tick();
        bus.flush_in = 1'b0;
        chk("flush.valid", bus.valid_out, 1'b0);
        #1;
        chk("flush.pending_cleared", bus.stall_out, 1'b0);
        tick();
        expect_out("i7", 1, 1, 0, 2'b01, 1, 12'h340, 32'd0, 5'd3, 0);

        // stall_in holds outputs for 3 cycles and must not set pending
        bus.stall_in = 1'b1; bus.instr_in = i8;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold.stall_out", bus.stall_out, 1'b0);
            tick();
            expect_out("hold", 1, 1, 0, 2'b01, 1, 12'h340, 32'd0, 5'd3, 0);
        end
        bus.stall_in = 1'b0;
        tick();
        expect_out("i8", 1, 1, 1, 2'b00, 1, 12'h305, 32'd8, 5'd4, 0);
        bus.instr_in = i7; #1;
        chk("i8.stall_pending", bus.stall_out, 1'b1);
        bus.stall_in = 1'b1; #1;
        chk("stall_out_indep_stall_in", bus.stall_out, 1'b1);

        // reset while pending
        reset = 1'b1;
        tick();
        expect_out("reset2", 0, 0, 0, 2'b00, 0, 12'h000, 32'd0, 5'd0, 0);
        chk("reset2.stall_out", bus.stall_out, 1'b0);
        reset = 1'b0; bus.stall_in = 1'b0;

        // set and retire in the same cycle: set wins
        bus.instr_in = i1; bus.csr_write_retired_in = 1'b1;
        tick();
        bus.csr_write_retired_in = 1'b0;
        expect_out("i1b", 1, 1, 1, 2'b00, 1, 12'h340, 32'd6, 5'd5, 0);
        bus.instr_in = i7; #1;
        chk("set_wins.stall_out", bus.stall_out, 1'b1);

        bus.valid_in = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
